// File: rtl/led_status_pkg.sv
// Shared types and helpers for the front-panel status LEDs.
package led_status_pkg;

  // Transport mode as driven by the recorder/player controller.
  typedef enum logic [1:0] {
    MODE_IDLE  = 2'd0,
    MODE_PLAY  = 2'd1,
    MODE_REC   = 2'd2,
    MODE_PAUSE = 2'd3
  } mode_t;

  // Widest LED group the fill helper can produce.
  localparam int MASK_W = 32;

  // Thermometer fill from the top: lights bits [width-1 : width-count].
  function automatic logic [MASK_W-1:0] therm_fill(input int count, input int width);
    logic [MASK_W-1:0] mask;
    mask = '0;
    for (int i = 0; i < MASK_W; i++) begin
      if (i < width && i >= width - count) mask[i] = 1'b1;
    end
    return mask;
  endfunction

  // Absolute value of a width-bit signed value; the most negative code
  // saturates to the largest positive magnitude.
  function automatic logic [31:0] sat_abs(input int value, input int width);
    int max_mag;
    max_mag = (1 << (width - 1)) - 1;
    if (value >= 0) return 32'(value);
    if (value < -max_mag) return 32'(max_mag);
    return 32'(-value);
  endfunction

endpackage

// File: rtl/led_peak_meter.sv
// Volume level and peak-hold tracker for the green meter LEDs.
// level_o/peak_o present the values being loaded this edge, so the parent's
// output register shows them with a single clock of latency.
module led_peak_meter
  import led_status_pkg::*;
#(
  parameter  int SAMPLE_W   = 16,
  parameter  int METER_LEDS = 8,
  parameter  int PEAK_HOLD  = 12000000,
  parameter  int DECAY_DIV  = 1500000,
  localparam int LVL_W      = $clog2(METER_LEDS + 1)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic                clear_i,
  input  logic [SAMPLE_W-1:0] sample_i,
  input  logic                valid_i,
  output logic [LVL_W-1:0]    level_o,
  output logic [LVL_W-1:0]    peak_o
);

  localparam int HOLD_W = $clog2(PEAK_HOLD + 1);
  localparam int DEC_W  = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

  logic [31:0]       mag;
  logic [31:0]       scaled;
  logic [LVL_W-1:0]  new_level;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [LVL_W-1:0]  peak_q, peak_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [DEC_W-1:0]  decay_q, decay_d;

  // Map the sample magnitude onto 0..METER_LEDS lit segments.
  always_comb begin
    mag       = sat_abs(32'(signed'(sample_i)), SAMPLE_W);
    scaled    = (mag * 32'(METER_LEDS + 1)) >> (SAMPLE_W - 1);
    new_level = (scaled >= 32'(METER_LEDS)) ? LVL_W'(METER_LEDS) : LVL_W'(scaled);
  end

  // Level capture, peak capture, hold countdown and stepwise peak decay.
  // NOTE: every variable gets its hold value first so no path infers a latch.
  always_comb begin
    level_d = level_q;
    peak_d  = peak_q;
    hold_d  = hold_q;
    decay_d = decay_q;
    if (clear_i) begin
      level_d = '0;
      peak_d  = '0;
      hold_d  = '0;
      decay_d = '0;
    end else if (enable_i) begin
      if (valid_i) level_d = new_level;
      // A new peak outranks a decay step landing on the same cycle.
      if (valid_i && new_level >= peak_q) begin
        peak_d  = new_level;
        hold_d  = HOLD_W'(PEAK_HOLD);
        decay_d = '0;
      end else if (hold_q != '0) begin
        hold_d = hold_q - HOLD_W'(1);
      end else if (decay_q == DEC_W'(DECAY_DIV - 1)) begin
        decay_d = '0;
        if (peak_q != '0) peak_d = peak_q - LVL_W'(1);
      end else begin
        decay_d = decay_q + DEC_W'(1);
      end
    end
  end

  // Meter state registers, cleared asynchronously.
  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      level_q <= '0;
      peak_q  <= '0;
      hold_q  <= '0;
      decay_q <= '0;
    end else begin
      level_q <= level_d;
      peak_q  <= peak_d;
      hold_q  <= hold_d;
      decay_q <= decay_d;
    end
  end

  assign level_o = level_d;
  assign peak_o  = peak_d;

endmodule

// File: rtl/led_status_meter.sv
// Front-panel driver: progress bar with blinking frontier, full/mode
// indicators on LEDR and a peak-hold volume meter on LEDG.
module led_status_meter
  import led_status_pkg::*;
#(
  parameter int               ADDR_W     = 20,
  parameter int               BAR_LEDS   = 15,
  parameter int               METER_LEDS = 8,
  parameter int               SAMPLE_W   = 16,
  parameter logic [ADDR_W-1:0] FULL_ADDR = 20'hF0000,
  parameter int               BLINK_DIV  = 6000000,
  parameter int               PEAK_HOLD  = 12000000,
  parameter int               DECAY_DIV  = 1500000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [1:0]            i_mode,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic [SAMPLE_W-1:0]   i_sample,
  input  logic                  i_sample_valid,
  output logic [BAR_LEDS+2:0]   o_ledr,
  output logic [METER_LEDS-1:0] o_ledg
);

  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int PROD_W  = ADDR_W + $clog2(BAR_LEDS + 1);
  localparam int LVL_W   = $clog2(METER_LEDS + 1);

  mode_t                 mode, mode_q;
  logic                  transport;
  logic [BLINK_W-1:0]    blink_cnt_q, blink_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  logic [PROD_W-1:0]     addr_prod;
  logic [PROD_W-1:0]     addr_top;
  int                    bar_count;
  logic [BAR_LEDS-1:0]   bar_mask;
  logic [METER_LEDS-1:0] meter_mask;
  logic [BAR_LEDS+2:0]   ledr_d;
  logic [METER_LEDS-1:0] ledg_d;
  logic [LVL_W-1:0]      level, peak;

  assign mode      = mode_t'(i_mode);
  assign transport = (mode == MODE_PLAY) || (mode == MODE_REC);

  led_peak_meter #(
    .SAMPLE_W  (SAMPLE_W),
    .METER_LEDS(METER_LEDS),
    .PEAK_HOLD (PEAK_HOLD),
    .DECAY_DIV (DECAY_DIV)
  ) u_peak_meter (
    .clk_i   (i_clk),
    .rst_i   (i_rst),
    .enable_i(transport),
    .clear_i (mode == MODE_IDLE),
    .sample_i(i_sample),
    .valid_i (i_sample_valid),
    .level_o (level),
    .peak_o  (peak)
  );

  // Blink timebase; a mode change restarts it in the lit phase.
  always_comb begin
    blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
    blink_phase_d = blink_phase_q;
    if (mode != mode_q) begin
      blink_cnt_d   = '0;
      blink_phase_d = 1'b1;
    end else if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
      blink_cnt_d   = '0;
      blink_phase_d = ~blink_phase_q;
    end
  end

  // Progress count: scale the address onto the bar with the full product.
  always_comb begin
    addr_prod = PROD_W'(i_addr) * PROD_W'(BAR_LEDS);
    addr_top  = addr_prod >> ADDR_W;
    if (i_addr == '0) bar_count = 0;
    else if (int'(addr_top) + 1 >= BAR_LEDS) bar_count = BAR_LEDS;
    else bar_count = int'(addr_top) + 1;
  end

  // Bar and meter patterns for the phase and levels entered this edge.
  always_comb begin
    bar_mask = BAR_LEDS'(therm_fill(bar_count, BAR_LEDS));
    for (int i = 0; i < BAR_LEDS; i++) begin
      if (transport && bar_count > 0 && i == BAR_LEDS - bar_count) bar_mask[i] = blink_phase_d;
    end

    meter_mask = METER_LEDS'(therm_fill(int'(level), METER_LEDS));
    for (int i = 0; i < METER_LEDS; i++) begin
      if (peak != '0 && i == METER_LEDS - int'(peak)) meter_mask[i] = 1'b1;
    end

    ledr_d = {mode == MODE_REC, mode == MODE_PLAY, i_addr >= FULL_ADDR, bar_mask};

    unique case (mode)
      MODE_PLAY, MODE_REC: ledg_d = meter_mask;
      MODE_PAUSE:          ledg_d = {METER_LEDS{blink_phase_d}};
      default:             ledg_d = '0;
    endcase
  end

  // Output and timebase registers, cleared asynchronously.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mode_q        <= MODE_IDLE;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
      o_ledr        <= '0;
      o_ledg        <= '0;
    end else begin
      mode_q        <= mode;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      o_ledr        <= ledr_d;
      o_ledg        <= ledg_d;
    end
  end

endmodule

// File: tb/tb_led_status_meter.sv
// Randomized and directed bench for led_status_meter against a
// behavioural model derived from elapsed-time arithmetic.
module tb_led_status_meter;

  localparam int ADDR_W     = 20;
  localparam int BAR_LEDS   = 15;
  localparam int METER_LEDS = 8;
  localparam int SAMPLE_W   = 16;
  localparam int BLINK_DIV  = 4;
  localparam int PEAK_HOLD  = 6;
  localparam int DECAY_DIV  = 2;

  logic                  i_clk = 1'b0;
  logic                  i_rst;
  logic [1:0]            i_mode;
  logic [ADDR_W-1:0]     i_addr;
  logic [SAMPLE_W-1:0]   i_sample;
  logic                  i_sample_valid;
  logic [BAR_LEDS+2:0]   o_ledr;
  logic [METER_LEDS-1:0] o_ledg;

  led_status_meter #(
    .ADDR_W    (ADDR_W),
    .BAR_LEDS  (BAR_LEDS),
    .METER_LEDS(METER_LEDS),
    .SAMPLE_W  (SAMPLE_W),
    .FULL_ADDR (20'hF0000),
    .BLINK_DIV (BLINK_DIV),
    .PEAK_HOLD (PEAK_HOLD),
    .DECAY_DIV (DECAY_DIV)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_mode        (i_mode),
    .i_addr        (i_addr),
    .i_sample      (i_sample),
    .i_sample_valid(i_sample_valid),
    .o_ledr        (o_ledr),
    .o_ledg        (o_ledg)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Model state: edges since the last mode change, meter level, and the
  // last captured peak together with edges elapsed since it was captured.
  int m_edges;
  int m_prev_mode;
  int m_level;
  int m_peak_base;
  int m_peak_age;
  logic [BAR_LEDS+2:0]   exp_ledr;
  logic [METER_LEDS-1:0] exp_ledg;

  function automatic int peak_now();
    int steps;
    steps = (m_peak_age > PEAK_HOLD) ? (m_peak_age - PEAK_HOLD) / DECAY_DIV : 0;
    return (m_peak_base > steps) ? m_peak_base - steps : 0;
  endfunction

  task automatic model_reset();
    m_edges     = 0;
    m_prev_mode = 0;
    m_level     = 0;
    m_peak_base = 0;
    m_peak_age  = 0;
    exp_ledr    = '0;
    exp_ledg    = '0;
  endtask

  task automatic model_step();
    int mode, phase, k, pk, sv, mag, lvl;
    logic signed [SAMPLE_W-1:0] s;
    logic lit;
    mode = int'(i_mode);
    if (mode != m_prev_mode) m_edges = 0;
    else m_edges++;
    m_prev_mode = mode;
    phase = ((m_edges / BLINK_DIV) % 2 == 0) ? 1 : 0;

    if (mode == 0) begin
      m_level     = 0;
      m_peak_base = 0;
      m_peak_age  = 0;
    end else if (mode == 1 || mode == 2) begin
      pk = peak_now();
      if (i_sample_valid) begin
        s   = i_sample;
        sv  = s;
        mag = (sv == -32768) ? 32767 : ((sv < 0) ? -sv : sv);
        lvl = mag * (METER_LEDS + 1) / 32768;
        if (lvl > METER_LEDS) lvl = METER_LEDS;
        m_level = lvl;
        if (lvl >= pk) begin
          m_peak_base = lvl;
          m_peak_age  = 0;
        end else m_peak_age++;
      end else m_peak_age++;
    end

    if (i_addr == '0) k = 0;
    else begin
      k = int'((longint'(i_addr) * BAR_LEDS) / (longint'(1) << ADDR_W)) + 1;
      if (k > BAR_LEDS) k = BAR_LEDS;
    end
    exp_ledr = '0;
    for (int j = 0; j < BAR_LEDS; j++) begin
      lit = (j >= BAR_LEDS - k);
      if ((mode == 1 || mode == 2) && k > 0 && j == BAR_LEDS - k) lit = (phase == 1);
      exp_ledr[j] = lit;
    end
    exp_ledr[BAR_LEDS]     = (i_addr >= 20'hF0000);
    exp_ledr[BAR_LEDS + 1] = (mode == 1);
    exp_ledr[BAR_LEDS + 2] = (mode == 2);

    pk = peak_now();
    exp_ledg = '0;
    if (mode == 1 || mode == 2) begin
      for (int j = 0; j < METER_LEDS; j++) begin
        exp_ledg[j] = (j >= METER_LEDS - m_level) || (pk > 0 && j == METER_LEDS - pk);
      end
    end else if (mode == 3) begin
      exp_ledg = (phase == 1) ? '1 : '0;
    end
  endtask

  task automatic drive(input logic [1:0] m, input logic [ADDR_W-1:0] a,
                       input logic [SAMPLE_W-1:0] s, input logic v);
    i_mode         = m;
    i_addr         = a;
    i_sample       = s;
    i_sample_valid = v;
  endtask

  // One clock: the model consumes the same inputs the DUT samples, then
  // both outputs are compared just after the edge.
  task automatic cycle(input string tag);
    @(posedge i_clk);
    model_step();
    #1;
    check({tag, "/ledr"}, 32'(o_ledr), 32'(exp_ledr));
    check({tag, "/ledg"}, 32'(o_ledg), 32'(exp_ledg));
  endtask

  logic [1:0]          mode_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [SAMPLE_W-1:0] sample_r;

  initial begin
    i_rst = 1'b1;
    drive(2'd0, '0, '0, 1'b0);
    model_reset();
    #12;
    check("reset_ledr", 32'(o_ledr), 32'd0);
    check("reset_ledg", 32'(o_ledg), 32'd0);
    @(negedge i_clk);
    i_rst = 1'b0;
    #1;

    // Progress bar sweep in record.
    drive(2'd2, 20'h00000, '0, 1'b0);
    for (int i = 0; i < 3; i++) cycle("bar_zero");
    drive(2'd2, 20'h10000, '0, 1'b0);
    for (int i = 0; i < 10; i++) cycle("bar_k1");
    drive(2'd2, 20'h80000, '0, 1'b0);
    cycle("bar_k8");
    check("bar_k8_solid", 32'(o_ledr[14:8]), 32'h7F);
    check("bar_k8_low", 32'(o_ledr[6:0]), 32'h00);
    for (int i = 0; i < 9; i++) cycle("bar_k8");
    drive(2'd2, 20'hFFFFF, '0, 1'b0);
    cycle("bar_full");
    check("full_flag", 32'(o_ledr[15]), 32'd1);
    check("rec_led", 32'(o_ledr[17]), 32'd1);
    drive(2'd2, 20'hEFFFF, '0, 1'b0);
    cycle("below_full");
    drive(2'd2, 20'hF0000, '0, 1'b0);
    cycle("at_full");

    // Meter in play.
    drive(2'd1, 20'h40000, 16'hC000, 1'b1);
    cycle("meter_c000");
    check("meter_c000_const", 32'(o_ledg), 32'hF0);
    drive(2'd1, 20'h40000, 16'h8000, 1'b1);
    cycle("meter_8000");
    check("meter_8000_const", 32'(o_ledg), 32'hFF);

    // Peak hold then decay.
    drive(2'd1, 20'h40000, 16'h7FFF, 1'b1);
    cycle("decay_set");
    drive(2'd1, 20'h40000, 16'h0000, 1'b1);
    cycle("decay_zero");
    check("decay_hold_const", 32'(o_ledg), 32'h01);
    drive(2'd1, 20'h40000, 16'h0000, 1'b0);
    for (int i = 0; i < 22; i++) cycle("decay_run");

    // Valid sample tying the peak on the same edge as a decay step.
    drive(2'd1, 20'h40000, 16'h7FFF, 1'b1);
    cycle("tie_set");
    drive(2'd1, 20'h40000, 16'h0000, 1'b0);
    for (int i = 0; i < 17; i++) cycle("tie_wait");
    drive(2'd1, 20'h40000, 16'h3000, 1'b1);
    cycle("tie_hit");
    drive(2'd1, 20'h40000, 16'h0000, 1'b1);
    cycle("tie_after");
    check("tie_peak_held", 32'(o_ledg), 32'h20);
    drive(2'd1, 20'h40000, 16'h0000, 1'b0);
    for (int i = 0; i < 8; i++) cycle("tie_tail");

    // Pause blinks the meter and ignores samples.
    for (int i = 0; i < 8; i++) begin
      drive(2'd3, 20'h40000, 16'h8000, 1'b1);
      cycle("pause");
      check("pause_blink", 32'(o_ledg), (i < 4) ? 32'hFF : 32'h00);
    end
    drive(2'd1, 20'h40000, 16'h0000, 1'b0);
    for (int i = 0; i < 4; i++) cycle("resume");

    // Asynchronous reset mid-record.
    drive(2'd2, 20'h90000, 16'h7FFF, 1'b1);
    cycle("pre_reset");
    #2 i_rst = 1'b1;
    #1;
    check("async_rst_ledr", 32'(o_ledr), 32'd0);
    check("async_rst_ledg", 32'(o_ledg), 32'd0);
    model_reset();
    #2 i_rst = 1'b0;
    drive(2'd2, 20'h90000, 16'hC000, 1'b1);
    cycle("post_reset");
    check("post_reset_fresh", 32'(o_ledg), 32'hF0);

    // Randomized traffic.
    mode_r = 2'd2;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 39) == 0) mode_r = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 5))
        0:       addr_r = '0;
        1:       addr_r = 20'hFFFFF;
        2:       addr_r = 20'hF0000;
        3:       addr_r = 20'hEFFFF;
        default: addr_r = ADDR_W'($urandom);
      endcase
      case ($urandom_range(0, 5))
        0:       sample_r = 16'h8000;
        1:       sample_r = 16'h7FFF;
        2:       sample_r = 16'h0000;
        default: sample_r = SAMPLE_W'($urandom);
      endcase
      drive(mode_r, addr_r, sample_r, $urandom_range(0, 2) == 0);
      cycle("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
